// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, break-safe error recovery.
// Define UART_RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_rx #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic             rx_meta;
  logic             rxs;
  logic             rxs_prev;
  logic [1:0]       settle_cnt;
  logic             settled;
  logic             start_det;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [3:0]       tick_cnt;
  logic             sample;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             shift_en;
  logic             load_data;
  logic             set_valid;
  logic             set_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Edge detection waits until the synchroniser has flushed its reset value, so a
  // line that is already low when reset releases is not taken as a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 2'd0;
      rxs_prev   <= 1'b0;
    end else begin
      if (!settled) settle_cnt <= settle_cnt + 2'd1;
      rxs_prev <= settled ? rxs : 1'b0;
    end
  end

  assign settled   = (settle_cnt == 2'd2);
  assign start_det = settled & rxs_prev & ~rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if ((state == IDLE) && start_det) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= 4'd0;
    end else if (state == IDLE) begin
      tick_cnt <= 4'd0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 4'd1;
    end
  end

  assign sample = tick && (tick_cnt == 4'd7);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_bad;
  logic cap_par;
  logic set_perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= set_perr;
      if (cap_par) par_bit <= rxs;
    end
  end

  assign par_bad = ^{shift_reg, par_bit};
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    load_data  = 1'b0;
    set_valid  = 1'b0;
    set_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
    cap_par    = 1'b0;
    set_perr   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_det) state_next = START;
      end
      START: begin
        if (sample) state_next = rxs ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state_next = PARITY;
`else
          if (bit_cnt == 3'd7) state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          cap_par    = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (!rxs) begin
            set_ferr   = 1'b1;
            state_next = WAIT_HIGH;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad) begin
            set_perr   = 1'b1;
            state_next = IDLE;
          end
`endif
          else begin
            set_valid  = 1'b1;
            load_data  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WAIT_HIGH: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= set_valid;
      frame_err <= set_ferr;
      if (state == START) bit_cnt <= 3'd0;
      if (shift_en) begin
        shift_reg <= {rxs, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (load_data) rx_data <= shift_reg;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are described at byte level, the expected
// pulse is queued when a frame is sent, and a monitor pops it when the DUT pulses.
module tb_uart_rx;

  localparam int CLK_FREQ     = 1600000;
  localparam int BAUD_RATE    = 100000;
  localparam int CLKS_PER_BIT = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t       expq[$];
  exp_t       mon_e;
  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] last_data   = 8'h00;
  logic [7:0] abort_byte  = 8'h81;

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendBit(input logic b);
    rx = b;
    repeat (CLKS_PER_BIT) @(negedge clk);
  endtask

  // The expected outcome follows from the frame contents alone: a low stop bit is a
  // framing error, a bad parity bit a parity error, anything else delivers the byte.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input logic par_flip);
    exp_t e;
    if (!stop_val) begin
      e.kind = K_FERR;
      e.data = last_data;
    end else if (PARITY_ON && par_flip) begin
      e.kind = K_PERR;
      e.data = last_data;
    end else begin
      e.kind    = K_VALID;
      e.data    = data;
      last_data = data;
    end
    expq.push_back(e);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(data[i]);
    if (PARITY_ON) sendBit((^data) ^ par_flip);
    sendBit(stop_val);
  endtask

  always @(negedge clk) begin
    if (rx_valid || frame_err || parity_err) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_pulse", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("pulse_kind", {29'd0, rx_valid, frame_err, parity_err}, {29'd0, mon_e.kind});
        checkOutput("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
      end
    end
  end

  initial begin
    logic [7:0] rdata;
    logic       rstop;
    logic       rflip;
    int         gap;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);

    applyStimulus(8'hA5, 1'b1, 1'b0);
    checkOutput("busy_after_good", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);

    // Short low glitch must be rejected without any pulse.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("busy_after_glitch", {31'd0, busy}, 32'd0);

    // Break: stop bit low and the line stays low for 40 clocks.
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (24) @(negedge clk);
    checkOutput("busy_during_break", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("busy_after_break", {31'd0, busy}, 32'd0);
    repeat (8) @(negedge clk);

    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    repeat (8) @(negedge clk);

    // Reset in the middle of bit 4 of 0x81 aborts that frame.
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(abort_byte[i]);
    rx = abort_byte[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_data = 8'h00;
    checkOutput("rx_data_after_rst", {24'd0, rx_data}, 32'd0);
    checkOutput("busy_after_rst", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    for (int i = 5; i < 8; i++) sendBit(abort_byte[i]);
    sendBit(1'b1);
    repeat (16) @(negedge clk);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    checkOutput("busy_after_5a", {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);

    if (PARITY_ON) begin
      applyStimulus(8'h07, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      applyStimulus(8'h07, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
    end

    for (int n = 0; n < 24; n++) begin
      rdata = 8'($urandom);
      rstop = ($urandom_range(0, 7) != 0);
      rflip = PARITY_ON && ($urandom_range(0, 4) == 0);
      gap   = $urandom_range(0, 12);
      applyStimulus(rdata, rstop, rflip);
      if (!rstop) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        rx = 1'b1;
        repeat (4 + gap) @(negedge clk);
      end else begin
        repeat (gap) @(negedge clk);
      end
    end

    repeat (40) @(negedge clk);
    checkOutput("pending_expected", expq.size(), 32'd0);
    checkOutput("final_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
